seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, consecutive identical samples required before a digit is captured (range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, clocks without any capture before scan_lost asserts.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- AN  input  8  multiplexed anode scan, active-low; AN[5:0] = digit positions 0..5; AN[7:6] unused, expected high.
- cathode  input  8  segment drive, active-low; bit0=a … bit6=g, bit7=dp.
- err_clr  input  1  synchronous clear of seg_err.
- digits  output  24  decoded digits; digits[4i+3:4i] = position i.
- dp  output  6  decimal point per position, 1 = lit.
- frame_valid  output  1  one-cycle pulse when digits/dp update.
- seg_err  output  1  sticky: an undecodable pattern was captured.
- scan_lost  output  1  high while no capture has occurred for TIMEOUT_CYCLES.

Function
REQ-004 AN and cathode SHALL pass through a two-flop synchronizer before any other use.
REQ-005 A synchronized sample SHALL be valid only when exactly one of AN[5:0] is low and AN[7:6] are both high; its position index is that low bit.
REQ-006 A stability counter SHALL increment while the current valid sample (index and cathode) equals the previous cycle's sample, saturate at STABLE_CYCLES, and reset to 1 on any change or to 0 on an invalid sample.
REQ-007 A capture SHALL occur on the cycle the counter first reaches STABLE_CYCLES, and only once per dwell; a further capture requires a sample change.
REQ-008 Decode of inverted segments g..a (1 = lit): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 00->F (blank); any other pattern -> E and sets seg_err.
REQ-009 Capture SHALL write the decoded value and inverted cathode[7] into a shadow register for that position and set its bit in a 6-bit seen mask; recapture of a position before frame completion overwrites the shadow.
REQ-010 When the seen mask becomes 6'b111111, the next cycle SHALL copy all shadows to digits/dp simultaneously, pulse frame_valid high for exactly one cycle, and clear the mask; latency from final capture to frame_valid is 1 clock.
REQ-011 A capture on the same cycle as the mask clear SHALL be recorded in the new frame's mask.
REQ-012 An idle counter SHALL clear on every capture and otherwise increment, saturating; scan_lost = 1 when it reaches TIMEOUT_CYCLES.
REQ-013 On scan_lost assertion the seen mask SHALL clear; digits/dp hold last values; scan_lost deasserts the cycle after the next capture.
REQ-014 seg_err SHALL clear when err_clr is high, except that a simultaneous error capture keeps it set (set wins).
REQ-015 Invalid samples (none or multiple anodes low) SHALL neither capture nor change the seen mask.

Reset
REQ-016 Asynchronous reset SHALL force: synchronizers to all-ones, counters to 0, seen mask to 0, shadows and digits to 24'hFFFFFF, dp to 0, frame_valid 0, seg_err 0, scan_lost 0.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame; after release the first frame_valid requires six new captures.

Verification
REQ-018 Scan positions 0..5 with patterns for 1,2,3,4,5,6, each held 10 clocks, no dp -> one frame_valid pulse, digits = 24'h654321, dp = 0.
REQ-019 Hold position 2 with pattern 5B for only 3 clocks (STABLE_CYCLES=4) inside an otherwise valid scan -> no capture at position 2, no frame_valid.
REQ-020 Drive position 3 with 7F and cathode[7] low, other positions valid -> nibble 3 = 8, dp[3] = 1; then pattern 49 at position 0 -> nibble 0 = E, seg_err = 1; err_clr pulse -> seg_err = 0.
REQ-021 AN = 8'b11110011 (two positions low) for 20 clocks -> no capture, mask unchanged.
REQ-022 TIMEOUT_CYCLES=50, stop scanning after 3 captures -> scan_lost high at idle count 50, mask cleared, digits hold; resume scan -> scan_lost low, full frame required for frame_valid.
REQ-023 Assert reset after 4 of 6 captures -> all outputs at reset values; after release, six captures -> single frame_valid.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers six digits from a multiplexed 7-segment scan
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  AN,
    input  logic [7:0]  cathode,
    input  logic        err_clr,
    output logic [23:0] digits,
    output logic [5:0]  dp,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        scan_lost
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0]    an_s1_q, an_s2_q, cat_s1_q, cat_s2_q;
    logic [7:0]    an_prev_q, cat_prev_q;
    logic [7:0]    cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [5:0]    seen_q, seen_d;
    logic [23:0]   shadow_q, shadow_d, digits_q;
    logic [5:0]    sdp_q, sdp_d, dp_q;
    logic          fv_q, err_q, lost_q, lost_d, err_d;
    logic [2:0]    idx;
    logic          valid, same, cap, bad;
    logic [6:0]    seg;
    logic [3:0]    nib;

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign frame_valid = fv_q;
    assign seg_err     = err_q;
    assign scan_lost   = lost_q;

    // Two-flop synchronizers; idle level is all-ones (nothing driven).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_s1_q  <= '1;
            an_s2_q  <= '1;
            cat_s1_q <= '1;
            cat_s2_q <= '1;
        end else begin
            an_s1_q  <= AN;
            an_s2_q  <= an_s1_q;
            cat_s1_q <= cathode;
            cat_s2_q <= cat_s1_q;
        end
    end

    // Sample qualification, dwell counting, segment decode and frame assembly.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 6; i++) if (!an_s2_q[i]) idx = 3'(i);
        valid  = an_s2_q[7:6] == 2'b11 && $onehot(~an_s2_q[5:0]);
        same   = an_s2_q == an_prev_q && cat_s2_q == cat_prev_q;
        cap    = valid && same && cnt_q == 8'(STABLE_CYCLES - 1);
        cnt_d  = !valid ? 8'd0 : !same ? 8'd1 : cnt_q == 8'(STABLE_CYCLES) ? cnt_q : cnt_q + 8'd1;
        seg    = ~cat_s2_q[6:0];
        bad    = 1'b0;
        case (seg)
            7'h3F:   nib = 4'h0;
            7'h06:   nib = 4'h1;
            7'h5B:   nib = 4'h2;
            7'h4F:   nib = 4'h3;
            7'h66:   nib = 4'h4;
            7'h6D:   nib = 4'h5;
            7'h7D:   nib = 4'h6;
            7'h07:   nib = 4'h7;
            7'h7F:   nib = 4'h8;
            7'h6F:   nib = 4'h9;
            7'h00:   nib = 4'hF;
            default: begin
                nib = 4'hE;
                bad = 1'b1;
            end
        endcase
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        if (cap) begin
            shadow_d[{idx, 2'b00} +: 4] = nib;
            sdp_d[idx]                  = ~cat_s2_q[7];
        end
        idle_d = cap ? '0 : lost_q ? idle_q : idle_q + 1'b1;
        lost_d = idle_d == IW'(TIMEOUT_CYCLES);
        // Mask clears on frame completion or loss, but a capture in that same cycle belongs to the new frame.
        seen_d = ((&seen_q || lost_d) ? 6'd0 : seen_q) | (cap ? 6'd1 << idx : 6'd0);
        err_d  = (cap && bad) || (err_q && !err_clr);
    end

    // State and registered outputs; a full mask publishes all shadows at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_prev_q  <= '1;
            cat_prev_q <= '1;
            cnt_q      <= '0;
            idle_q     <= '0;
            seen_q     <= '0;
            shadow_q   <= '1;
            sdp_q      <= '0;
            digits_q   <= '1;
            dp_q       <= '0;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            an_prev_q  <= an_s2_q;
            cat_prev_q <= cat_s2_q;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            seen_q     <= seen_d;
            shadow_q   <= shadow_d;
            sdp_q      <= sdp_d;
            digits_q   <= &seen_q ? shadow_q : digits_q;
            dp_q       <= &seen_q ? sdp_q : dp_q;
            fv_q       <= &seen_q;
            err_q      <= err_d;
            lost_q     <= lost_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: vector table, directed corner sequences and a randomized scan vs a dwell-level model
module tb_seg_scan_decoder;
    localparam int ST = 4;
    localparam int TO = 50;

    logic        clk = 1'b0, reset = 1'b1, err_clr = 1'b0;
    logic [7:0]  AN = 8'hFF, cathode = 8'hFF;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic        frame_valid, seg_err, scan_lost;

    seg_scan_decoder #(.STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .AN(AN), .cathode(cathode), .err_clr(err_clr),
        .digits(digits), .dp(dp), .frame_valid(frame_valid), .seg_err(seg_err), .scan_lost(scan_lost)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, fv_n = 0, fv_cyc = 0;
    logic [23:0] got_dig[$];
    logic [5:0]  got_dp[$];
    logic [6:0]  codes[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (frame_valid) begin
            fv_n = fv_n + 1;
            fv_cyc = cyc;
            got_dig.push_back(digits);
            got_dp.push_back(dp);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] an_of(input int p);
        return ~(8'd1 << p);
    endfunction

    function automatic logic [7:0] cat_of(input logic [6:0] pat, input logic dpl);
        return {~dpl, ~pat};
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] c, input int n);
        AN = a;
        cathode = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic pos(input int p, input logic [6:0] pat, input logic dpl, input int n);
        drive(an_of(p), cat_of(pat, dpl), n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        AN = 8'hFF;
        cathode = 8'hFF;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    // dwell-level reference model
    logic [3:0]  m_dig[6];
    logic        m_dp[6];
    logic [5:0]  m_seen;
    logic        m_err;
    logic [23:0] exp_dig[$];
    logic [5:0]  exp_dp[$];
    logic [7:0]  cur_an, cur_cat;
    logic        cur_v;
    int          cur_len;

    function automatic logic [3:0] mdec(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (codes[i] == s) return 4'(i);
        return s == 7'h00 ? 4'hF : 4'hE;
    endfunction

    task automatic m_final();
        int p;
        logic [23:0] w;
        logic [5:0] wd;
        if (cur_v && cur_len >= ST) begin
            p = 0;
            for (int i = 0; i < 6; i++) if (!cur_an[i]) p = i;
            m_dig[p] = mdec(~cur_cat[6:0]);
            m_dp[p] = ~cur_cat[7];
            if (m_dig[p] == 4'hE) m_err = 1'b1;
            m_seen[p] = 1'b1;
            if (&m_seen) begin
                for (int i = 0; i < 6; i++) begin
                    w[4*i +: 4] = m_dig[i];
                    wd[i] = m_dp[i];
                end
                exp_dig.push_back(w);
                exp_dp.push_back(wd);
                m_seen = '0;
            end
        end
    endtask

    typedef struct {
        logic [6:0] pat;
        logic [3:0] nib;
        logic       err;
    } vec_t;
    vec_t tbl[14];

    initial begin
        int n0, k, since, p, len;
        logic [7:0] a, c;
        logic v;

        // reset state
        do_reset();
        chk("rst_digits", 32'(digits), 32'hFFFFFF);
        chk("rst_dp", 32'(dp), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        chk("rst_err", 32'(seg_err), 0);
        chk("rst_lost", 32'(scan_lost), 0);

        // decode table: every position shows the same pattern, dp on one position
        for (int i = 0; i < 10; i++) tbl[i] = '{codes[i], 4'(i), 1'b0};
        tbl[10] = '{7'h00, 4'hF, 1'b0};
        tbl[11] = '{7'h49, 4'hE, 1'b1};
        tbl[12] = '{7'h7E, 4'hE, 1'b1};
        tbl[13] = '{7'h01, 4'hE, 1'b1};
        for (int i = 0; i < 14; i++) begin
            pulse_clr();
            n0 = fv_n;
            for (int q = 0; q < 6; q++) pos(q, tbl[i].pat, q == i % 6, 5);
            drive(8'hFF, 8'hFF, 10);
            chk($sformatf("tbl%0d_fv", i), fv_n, n0 + 1);
            chk($sformatf("tbl%0d_digits", i), 32'(digits), 32'({6{tbl[i].nib}}));
            chk($sformatf("tbl%0d_dp", i), 32'(dp), 32'(6'd1 << (i % 6)));
            chk($sformatf("tbl%0d_err", i), 32'(seg_err), 32'(tbl[i].err));
        end

        // basic scan 1..6 and capture-to-frame latency
        do_reset();
        n0 = fv_n;
        for (int q = 0; q < 5; q++) pos(q, codes[q+1], 1'b0, 10);
        k = cyc;
        pos(5, codes[6], 1'b0, 10);
        drive(8'hFF, 8'hFF, 10);
        chk("scan_fv", fv_n, n0 + 1);
        chk("scan_latency", fv_cyc, k + 7);
        chk("scan_digits", 32'(digits), 32'h654321);
        chk("scan_dp", 32'(dp), 0);

        // short dwell at position 2 is not captured
        do_reset();
        n0 = fv_n;
        pos(0, codes[1], 1'b0, 10);
        pos(1, codes[2], 1'b0, 10);
        pos(2, 7'h5B, 1'b0, 3);
        for (int q = 3; q < 6; q++) pos(q, codes[q+1], 1'b0, 10);
        drive(8'hFF, 8'hFF, 10);
        chk("short_nofv", fv_n, n0);
        pos(2, 7'h5B, 1'b0, 10);
        drive(8'hFF, 8'hFF, 10);
        chk("short_fill_fv", fv_n, n0 + 1);
        chk("short_fill_digits", 32'(digits), 32'h654221);

        // dp capture, error capture, error clear, set-wins
        do_reset();
        for (int q = 0; q < 6; q++) pos(q, q == 3 ? 7'h7F : codes[q], q == 3, 10);
        drive(8'hFF, 8'hFF, 10);
        chk("dp_nib3", 32'(digits[15:12]), 8);
        chk("dp_dp", 32'(dp), 32'h08);
        chk("dp_noerr", 32'(seg_err), 0);
        for (int q = 0; q < 6; q++) pos(q, q == 0 ? 7'h49 : q == 3 ? 7'h7F : codes[q], q == 3, 10);
        drive(8'hFF, 8'hFF, 10);
        chk("err_nib0", 32'(digits[3:0]), 32'hE);
        chk("err_set", 32'(seg_err), 1);
        pulse_clr();
        chk("err_clr", 32'(seg_err), 0);
        err_clr = 1'b1;
        pos(0, 7'h49, 1'b0, 6);
        chk("err_setwins", 32'(seg_err), 1);
        @(negedge clk);
        chk("err_clr_after", 32'(seg_err), 0);
        err_clr = 1'b0;
        drive(8'hFF, 8'hFF, 10);

        // two anodes low: ignored
        do_reset();
        n0 = fv_n;
        for (int q = 0; q < 3; q++) pos(q, codes[q+1], 1'b0, 10);
        drive(8'hF3, cat_of(codes[7], 1'b0), 20);
        for (int q = 3; q < 6; q++) pos(q, codes[q+1], 1'b0, 10);
        drive(8'hFF, 8'hFF, 10);
        chk("multi_fv", fv_n, n0 + 1);
        chk("multi_digits", 32'(digits), 32'h654321);

        // scan loss and recovery
        do_reset();
        for (int q = 0; q < 6; q++) pos(q, codes[q+1], 1'b0, 10);
        drive(8'hFF, 8'hFF, 10);
        pos(0, codes[7], 1'b0, 10);
        pos(1, codes[8], 1'b0, 10);
        k = cyc;
        pos(2, codes[9], 1'b0, 10);
        drive(8'hFF, 8'hFF, 45);
        chk("lost_before", 32'(scan_lost), 0);
        drive(8'hFF, 8'hFF, 1);
        chk("lost_at50", 32'(scan_lost), 1);
        drive(8'hFF, 8'hFF, 20);
        chk("lost_hold", 32'(scan_lost), 1);
        chk("lost_digits_hold", 32'(digits), 32'h654321);
        n0 = fv_n;
        pos(3, codes[0], 1'b0, 5);
        chk("lost_prec", 32'(scan_lost), 1);
        pos(3, codes[0], 1'b0, 1);
        chk("lost_recover", 32'(scan_lost), 0);
        pos(3, codes[0], 1'b0, 4);
        pos(4, codes[0], 1'b0, 10);
        pos(5, codes[0], 1'b0, 10);
        drive(8'hFF, 8'hFF, 10);
        chk("lost_mask_cleared", fv_n, n0);
        for (int q = 0; q < 3; q++) pos(q, codes[q+7], 1'b0, 10);
        drive(8'hFF, 8'hFF, 10);
        chk("lost_refill_fv", fv_n, n0 + 1);
        chk("lost_refill_digits", 32'(digits), 32'h000987);

        // reset mid-frame
        do_reset();
        for (int q = 0; q < 6; q++) pos(q, q == 0 ? 7'h49 : codes[q], q == 1, 10);
        drive(8'hFF, 8'hFF, 10);
        for (int q = 0; q < 4; q++) pos(q, codes[q+1], 1'b0, 10);
        reset = 1'b1;
        #1;
        chk("mid_rst_digits", 32'(digits), 32'hFFFFFF);
        chk("mid_rst_dp", 32'(dp), 0);
        chk("mid_rst_fv", 32'(frame_valid), 0);
        chk("mid_rst_err", 32'(seg_err), 0);
        chk("mid_rst_lost", 32'(scan_lost), 0);
        AN = 8'hFF;
        cathode = 8'hFF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n0 = fv_n;
        pos(4, codes[5], 1'b0, 10);
        pos(5, codes[6], 1'b0, 10);
        for (int q = 0; q < 3; q++) pos(q, codes[q+1], 1'b0, 10);
        drive(8'hFF, 8'hFF, 10);
        chk("mid_rst_partial", fv_n, n0);
        pos(3, codes[4], 1'b0, 10);
        drive(8'hFF, 8'hFF, 10);
        chk("mid_rst_fv", fv_n, n0 + 1);
        chk("mid_rst_digits2", 32'(digits), 32'h654321);

        // randomized scan vs dwell model
        do_reset();
        got_dig.delete();
        got_dp.delete();
        m_seen = '0;
        m_err = 1'b0;
        cur_an = 8'hFF;
        cur_cat = 8'hFF;
        cur_v = 1'b0;
        cur_len = 0;
        since = 0;
        for (int d = 0; d < 150; d++) begin
            p = $urandom_range(0, 5);
            len = $urandom_range(1, 8);
            if (since > 16) begin
                v = 1'b1;
                a = an_of(p);
                c = cat_of(codes[$urandom_range(0, 9)], 1'($urandom_range(0, 1)));
                len = 8;
            end else if ($urandom_range(0, 9) == 0) begin
                v = 1'b0;
                a = $urandom_range(0, 1) ? 8'hFF : (an_of(p) & an_of((p + 1) % 6));
                c = 8'($urandom);
            end else begin
                v = 1'b1;
                a = an_of(p);
                c = $urandom_range(0, 9) < 7 ? cat_of(codes[$urandom_range(0, 9)], 1'($urandom_range(0, 1))) : 8'($urandom);
            end
            if (a == cur_an && c == cur_cat) cur_len += len;
            else begin
                m_final();
                cur_an = a;
                cur_cat = c;
                cur_v = v;
                cur_len = len;
            end
            since = (cur_v && cur_len >= ST) ? 0 : since + len;
            drive(a, c, len);
        end
        drive(8'hFF, 8'hFF, 10);
        m_final();
        chk("rand_frames", got_dig.size(), exp_dig.size());
        for (int i = 0; i < exp_dig.size() && i < got_dig.size(); i++) begin
            chk($sformatf("rand_digits%0d", i), 32'(got_dig[i]), 32'(exp_dig[i]));
            chk($sformatf("rand_dp%0d", i), 32'(got_dp[i]), 32'(exp_dp[i]));
        end
        chk("rand_err", 32'(seg_err), 32'(m_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
